// File: rtl/sssp_update_packer.sv
// Packs up to N_PIPE 64-bit SSSP updates per cycle densely into 512-bit lines and
// writes them to consecutive line addresses through a small valid/ready line queue.
module sssp_update_packer #(
  parameter int unsigned N_PIPE  = 4,
  parameter int unsigned Q_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic [64*N_PIPE-1:0]  word_in,
  input  logic [N_PIPE-1:0]     valid_in,
  input  logic                  last_input_in,
  output logic [511:0]          wr_data,
  output logic [31:0]           wr_addr,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic                  done,
  output logic                  busy,
  output logic [31:0]           update_count,
  output logic                  overflow
);
  localparam int unsigned AW = $clog2(Q_DEPTH);
  localparam logic [63:0] PadWord = '1;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDrain} state_e;
  state_e state_q, state_d;

  logic [2:0]   fill_q, fill_d;
  logic [511:0] line_q, line_d;
  logic [31:0]  addr_q, count_q;
  logic         ovf_q, done_q;

  logic [63:0]  packed_w [8];
  logic [63:0]  slot_w [16];
  logic [3:0]   pop_cnt, sum;
  logic [511:0] done_line;
  logic         push_req, push_ok, pop, q_full, q_empty, drain_empty;

  logic [511:0]  q_data [Q_DEPTH];
  logic [31:0]   q_addr [Q_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   q_cnt_q;

  // Compact valid lanes in ascending order; lanes are consumed only in RUN.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < 8; i++) packed_w[i] = PadWord;
    for (int k = 0; k < N_PIPE; k++) begin
      if (valid_in[k] && state_q == StRun) begin
        packed_w[pop_cnt[2:0]] = word_in[64*k +: 64];
        pop_cnt = pop_cnt + 4'd1;
      end
    end
  end

  // Two-line window: held slots, then packed words, padded with all-ones.
  always_comb begin
    sum = {1'b0, fill_q} + pop_cnt;
    for (int s = 0; s < 16; s++) slot_w[s] = PadWord;
    for (int s = 0; s < 8; s++) begin
      if (3'(s) < fill_q) slot_w[s] = line_q[64*s +: 64];
    end
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < pop_cnt) slot_w[{1'b0, fill_q} + 4'(i)] = packed_w[i];
    end
    for (int s = 0; s < 8; s++) done_line[64*s +: 64] = slot_w[s];
  end

  always_comb begin
    fill_d   = fill_q;
    line_d   = line_q;
    push_req = 1'b0;
    case (state_q)
      StIdle: if (start) fill_d = '0;
      StRun: begin
        fill_d   = sum[2:0];
        push_req = sum[3];
        for (int s = 0; s < 8; s++) begin
          line_d[64*s +: 64] = sum[3] ? slot_w[s + 8] : slot_w[s];
        end
      end
      StFlush: begin
        push_req = 1'b1;
        fill_d   = '0;
      end
      default: ;
    endcase
  end

  assign q_empty     = (q_cnt_q == '0);
  assign q_full      = (q_cnt_q == (AW+1)'(Q_DEPTH));
  assign pop         = !q_empty && wr_ready;
  assign push_ok     = push_req && (!q_full || pop);
  assign drain_empty = q_empty || (q_cnt_q == (AW+1)'(1) && pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_input_in) state_d = (sum[2:0] != 3'd0) ? StFlush : StDrain;
      StFlush: state_d = StDrain;
      StDrain: if (drain_empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (state_q != StIdle);
    done         = done_q;
    wr_valid     = !q_empty;
    wr_data      = q_empty ? '0 : q_data[rd_ptr_q];
    wr_addr      = q_empty ? '0 : q_addr[rd_ptr_q];
    update_count = count_q;
    overflow     = ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q   <= '0;
      line_q   <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_cnt_q  <= '0;
    end else begin
      fill_q <= fill_d;
      line_q <= line_d;
      done_q <= (state_q == StDrain) && drain_empty;
      if (state_q == StIdle && start) begin
        addr_q  <= base_addr;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else begin
        count_q <= count_q + 32'(pop_cnt);
        // Address advances even for a dropped line so later lines keep their slots.
        if (push_req) addr_q <= addr_q + 32'd1;
        if (push_req && !push_ok) ovf_q <= 1'b1;
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   q_cnt_q <= q_cnt_q + (AW+1)'(1);
        2'b01:   q_cnt_q <= q_cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_data[wr_ptr_q] <= done_line;
      q_addr[wr_ptr_q] <= addr_q;
    end
  end

endmodule

// File: tb/tb_sssp_update_packer.sv
// Randomised and directed bench for sssp_update_packer against a queue-based model.
module tb_sssp_update_packer;
  localparam int NP = 4;
  localparam int QD = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [64*NP-1:0] word_in = '0;
  logic [NP-1:0]    valid_in = '0;
  logic             last_input_in = 1'b0;
  logic [511:0]     wr_data;
  logic [31:0]      wr_addr;
  logic             wr_valid;
  logic             wr_ready = 1'b1;
  logic             done, busy, overflow;
  logic [31:0]      update_count;

  sssp_update_packer #(.N_PIPE(NP), .Q_DEPTH(QD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_in(word_in),
    .valid_in(valid_in), .last_input_in(last_input_in), .wr_data(wr_data),
    .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready), .done(done),
    .busy(busy), .update_count(update_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int seq = 0;
  int acc_cyc = -1;
  int done_cyc = -1;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  bit rnd_ready = 1'b0;
  logic ready_set = 1'b1;

  typedef struct { logic [511:0] d; logic [31:0] a; } line_t;
  line_t       obs[$];
  line_t       m_lines[$];
  logic [63:0] m_words[$];
  int          m_phase = 0;  // 0 idle, 1 run, 2 flush, 3 drain
  logic [31:0] m_addr = '0, m_cnt = '0;
  logic        m_ovf = 1'b0, m_done = 1'b0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] seq_line(input int first, input int n);
    logic [511:0] l = '1;
    for (int s = 0; s < n; s++) l[64*s +: 64] = {32'(first + s), 32'(first + s)};
    return l;
  endfunction

  task automatic m_emit();
    line_t l;
    l.d = '1;
    l.a = m_addr;
    for (int s = 0; s < 8 && m_words.size() > 0; s++) l.d[64*s +: 64] = m_words.pop_front();
    if (m_lines.size() < QD) m_lines.push_back(l);
    else m_ovf = 1'b1;
    m_addr = m_addr + 32'd1;
  endtask

  // Reference model: a word queue packed eight at a time into a bounded line queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_words.delete(); m_lines.delete();
      m_addr = '0; m_cnt = '0; m_ovf = 1'b0; m_done = 1'b0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (m_lines.size() > 0 && wr_ready) void'(m_lines.pop_front());
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_addr = base_addr; m_cnt = '0; m_ovf = 1'b0; m_words.delete();
        end
        1: begin
          for (int k = 0; k < NP; k++) begin
            if (valid_in[k]) begin
              m_words.push_back(word_in[64*k +: 64]);
              m_cnt = m_cnt + 32'd1;
            end
          end
          if (m_words.size() >= 8) m_emit();
          if (last_input_in) m_phase = (m_words.size() > 0) ? 2 : 3;
        end
        2: begin m_emit(); m_phase = 3; end
        default: if (m_lines.size() == 0) begin m_done = 1'b1; m_phase = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("wr_valid", 512'(wr_valid), 512'(m_lines.size() != 0));
      if (m_lines.size() != 0) begin
        chk("wr_data", wr_data, m_lines[0].d);
        chk("wr_addr", 512'(wr_addr), 512'(m_lines[0].a));
      end
      chk("done", 512'(done), 512'(m_done));
      chk("busy", 512'(busy), 512'(m_phase != 0));
      chk("update_count", 512'(update_count), 512'(m_cnt));
      chk("overflow", 512'(overflow), 512'(m_ovf));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid && wr_ready) begin
        line_t l;
        l.d = wr_data; l.a = wr_addr;
        obs.push_back(l);
        acc_cyc = cyc;
      end
      if (done) begin done_cyc = cyc; done_cnt++; end
    end
  end

  always @(posedge clk) begin
    #2;
    wr_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_set;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1'b1; base_addr = b;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [NP-1:0] v, input logic lst);
    valid_in = v; last_input_in = lst;
    for (int k = 0; k < NP; k++) begin
      if (v[k]) begin word_in[64*k +: 64] = {32'(seq), 32'(seq)}; seq++; end
      else word_in[64*k +: 64] = {$urandom, $urandom};
    end
    step();
    valid_in = '0; last_input_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin step(); n++; end
    chk("done_timeout", 512'(done), 512'(1'b1));
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_valid", 512'(wr_valid), 512'(0));
    chk("rst_wr_data", wr_data, 512'(0));
    chk("rst_wr_addr", 512'(wr_addr), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_count", 512'(update_count), 512'(0));
    chk("rst_overflow", 512'(overflow), 512'(0));
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // Single full line.
    obs.delete(); seq = 0;
    do_start(32'h100);
    beat(4'b1111, 1'b0);
    beat(4'b1111, 1'b1);
    wait_done(100);
    chk("t1_lines", 512'(obs.size()), 512'(1));
    if (obs.size() >= 1) begin
      chk("t1_addr", 512'(obs[0].a), 512'(32'h100));
      chk("t1_data", obs[0].d, seq_line(0, 8));
    end
    chk("t1_count", 512'(update_count), 512'(8));
    chk("t1_done_lat", 512'(done_cyc - acc_cyc), 512'(1));

    // Spill into a padded second line.
    obs.delete(); seq = 0;
    do_start(32'h200);
    repeat (3) beat(4'b0111, 1'b0);
    beat(4'b0000, 1'b1);
    wait_done(100);
    chk("t2_lines", 512'(obs.size()), 512'(2));
    if (obs.size() >= 2) begin
      chk("t2_l0", obs[0].d, seq_line(0, 8));
      chk("t2_l1", obs[1].d, seq_line(8, 1));
      chk("t2_a1", 512'(obs[1].a), 512'(32'h201));
    end
    chk("t2_count", 512'(update_count), 512'(9));

    // Sparse lanes compact in lane order.
    obs.delete();
    do_start(32'h300);
    valid_in = 4'b1010; last_input_in = 1'b1;
    word_in = {64'hBBBB_0002_0000_0022, 64'h1111, 64'hAAAA_0001_0000_0011, 64'h2222};
    step();
    valid_in = '0; last_input_in = 1'b0;
    wait_done(100);
    chk("t3_lines", 512'(obs.size()), 512'(1));
    if (obs.size() >= 1) begin
      chk("t3_s0", 512'(obs[0].d[63:0]), 512'(64'hAAAA_0001_0000_0011));
      chk("t3_s1", 512'(obs[0].d[127:64]), 512'(64'hBBBB_0002_0000_0022));
      chk("t3_s2", 512'(obs[0].d[191:128]), 512'(64'hFFFF_FFFF_FFFF_FFFF));
    end

    // Backpressure, then a dropped third line.
    obs.delete(); seq = 0; ready_set = 1'b0;
    step();
    do_start(32'h400);
    repeat (4) beat(4'b1111, 1'b0);
    repeat (3) step();
    chk("t4_ovf0", 512'(overflow), 512'(0));
    chk("t4_held_addr", 512'(wr_addr), 512'(32'h400));
    repeat (2) beat(4'b1111, 1'b0);
    chk("t4_ovf1", 512'(overflow), 512'(1));
    ready_set = 1'b1;
    repeat (4) step();
    repeat (2) beat(4'b1111, 1'b0);
    beat(4'b0000, 1'b1);
    wait_done(100);
    chk("t4_lines", 512'(obs.size()), 512'(3));
    if (obs.size() >= 3) begin
      chk("t4_a0", 512'(obs[0].a), 512'(32'h400));
      chk("t4_d1", obs[1].d, seq_line(8, 8));
      chk("t4_a2", 512'(obs[2].a), 512'(32'h403));
      chk("t4_d2", obs[2].d, seq_line(24, 8));
    end
    chk("t4_count", 512'(update_count), 512'(32));

    // Empty pass.
    obs.delete();
    do_start(32'h500);
    begin
      int last_cyc;
      last_cyc = cyc;
      beat(4'b0000, 1'b1);
      wait_done(50);
      chk("t5_done_lat", 512'(done_cyc - last_cyc), 512'(2));
    end
    chk("t5_lines", 512'(obs.size()), 512'(0));
    chk("t5_count", 512'(update_count), 512'(0));

    // Reset mid-pass with fill 5 and one line queued.
    ready_set = 1'b0; seq = 0;
    step();
    do_start(32'h600);
    repeat (3) beat(4'b1111, 1'b0);
    beat(4'b0001, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_wr_valid", 512'(wr_valid), 512'(0));
    chk("t6_wr_data", wr_data, 512'(0));
    chk("t6_wr_addr", 512'(wr_addr), 512'(0));
    chk("t6_busy", 512'(busy), 512'(0));
    chk("t6_count", 512'(update_count), 512'(0));
    chk("t6_done", 512'(done), 512'(0));
    step();
    rst = 1'b0; ready_set = 1'b1;
    obs.delete();
    begin
      int dc;
      dc = done_cnt;
      repeat (8) step();
      chk("t6_no_write", 512'(obs.size()), 512'(0));
      chk("t6_no_done", 512'(done_cnt - dc), 512'(0));
    end

    // Randomised passes with random backpressure.
    rnd_ready = 1'b1;
    for (int p = 0; p < 8; p++) begin
      int n;
      seq = int'($urandom_range(0, 32'h0FFF_FFFF));
      do_start($urandom);
      n = int'($urandom_range(1, 30));
      for (int b = 0; b < n; b++) beat(NP'($urandom), b == n - 1);
      wait_done(400);
    end
    rnd_ready = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sssp_update_packer.md
# sssp_update_packer

Write-side consumer of the SSSP pipelines' 64-bit update stream. Each cycle it takes up to `N_PIPE` `{new_weight, dst}` update words and packs them densely, in order, into 512-bit cache lines of eight updates each. It queues the lines and writes them to consecutive line addresses over a valid/ready write interface. At end of pass it pads and flushes any partial line, then signals completion.

## Interface
Parameters:
- `N_PIPE`, 4: number of pipeline lanes; legal range 1..8.
- `Q_DEPTH`, 2: output line-queue depth in lines; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a pass; honoured only in IDLE.
- `base_addr`  in  32  line address (64 B units) of the first output line; sampled on `start`.
- `word_in`  in  64*N_PIPE  lane k at bits [64k+63:64k]; each word is {weight[63:32], dst[31:0]}.
- `valid_in`  in  N_PIPE  per-lane valid.
- `last_input_in`  in  1  final beat of the pass; words valid in the same cycle belong to the pass.
- `wr_data`  out  512  line; slot s at bits [64s+63:64s].
- `wr_addr`  out  32  line address of `wr_data`.
- `wr_valid`  out  1  line offered.
- `wr_ready`  in  1  consumer accepts when `wr_valid & wr_ready`.
- `done`  out  1  one-cycle pulse when the pass has been fully written.
- `busy`  out  1  high in every state except IDLE.
- `update_count`  out  32  valid updates accepted this pass; padding is not counted.
- `overflow`  out  1  sticky; set when a line is dropped because the queue is full.

## Operation
- States: IDLE, RUN, FLUSH, DRAIN.
- IDLE: `valid_in` and `last_input_in` are ignored.
  - `start` → RUN.
  - On `start`: load the next-address counter with `base_addr`; clear fill pointer, `update_count` and `overflow`.
- RUN: valid lanes are compacted in ascending lane order.
  - Packed words go into the current line starting at fill pointer `f` (0..7). Let `p = popcount(valid_in)`.
  - If `f + p < 8`: `f ← f + p`.
  - If `f + p ≥ 8`: the line completes. The remaining `f + p - 8` words start the next line at slot 0, and `f ← f + p - 8`. At most one line completes per cycle.
  - `update_count += p`; the counter wraps at 2^32.
  - A completed line is pushed to the queue tagged with the next address, and the address increments by 1 (mod 2^32).
  - If the queue is full at push (a simultaneous pop in the same cycle frees one entry), the line is dropped, the address still increments, and `overflow ← 1`.
- `last_input_in` in RUN: process that cycle's words first.
  - If the resulting fill is nonzero → FLUSH.
  - Otherwise → DRAIN.
- FLUSH (1 cycle): pad slots fill..7 with 64'hFFFF_FFFF_FFFF_FFFF (dst 0xFFFFFFFF = invalid), push the line under the same overflow rule, clear the fill pointer → DRAIN.
- DRAIN: once the queue is empty, pulse `done` and → IDLE.
- `start` outside IDLE is ignored.
- `valid_in` in FLUSH and DRAIN is ignored; a consumer that sends words there is in protocol error.
- Queue:
  - FIFO of `{data, addr}`; the head drives `wr_data` and `wr_addr`.
  - `wr_valid` = queue not empty.
  - Head data and address stay stable while `wr_valid & !wr_ready`.
- Reset mid-pass: all state is discarded immediately and the block returns to IDLE; no partial line is emitted.

## Timing
- Reset values:
  - `wr_valid` = 0, `wr_data` = 0, `wr_addr` = 0.
  - `done` = 0, `busy` = 0, `update_count` = 0, `overflow` = 0.
  - State IDLE, fill = 0, queue empty.
- `busy` rises the cycle after `start`.
- Latency: a line completed by the inputs of cycle t is at the queue tail at t+1. When the queue was empty, `wr_valid` = 1 at t+1.
- FLUSH occupies the cycle after `last_input_in`; the padded line is visible at the earliest 2 cycles after `last_input_in`.
- `done` asserts the cycle after the last queued line is accepted.
  - With zero outstanding lines, `done` asserts 2 cycles after `last_input_in` (DRAIN, queue empty).
  - `busy` falls together with the `done` pulse.
- Sustained input rate is 1 line/cycle when N_PIPE = 8. `wr_ready` low for more than Q_DEPTH line-completions sets `overflow`.

## Test plan
- Single line, no backpressure:
  - Stimulus: base 0x100, N_PIPE=4; two cycles of all lanes valid with words {w=i, dst=i} for i=0..7; `last_input_in` on the second cycle.
  - Response: one line at addr 0x100 with slot i = {i,i}; no pad line; `update_count` = 8; `done` 1 cycle after acceptance.
- Spill across lines:
  - Stimulus: 3 lanes valid for 3 cycles (9 words), then last.
  - Response: line 0 holds words 0..7 at base; line 1 holds word 8 in slot 0 and slots 1..7 all-ones, at base+1; count = 9.
- Sparse lanes:
  - Stimulus: `valid_in` = 4'b1010 with lane1 = A, lane3 = B.
  - Response: slot 0 = A, slot 1 = B (compacted, lane order).
- Backpressure:
  - Stimulus: `wr_ready` = 0 while 2 lines complete; then `wr_ready` = 1.
  - Response: both lines emitted in order with stable data during the stall; `overflow` = 0.
  - Then a 3rd line completes while the queue is still full → that line is dropped, `overflow` = 1, and later addresses skip it.
- Empty pass:
  - Stimulus: `start` then `last_input_in` with no valid words.
  - Response: no write; `done` 2 cycles later; count = 0.
- Reset mid-pass:
  - Stimulus: assert `rst` with fill = 5 and 1 line queued.
  - Response: all outputs at reset values asynchronously; after `rst` deasserts, no write and no `done`.
